// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the micro-step sequencer: state codes driven on
// Control_Unit STATE, opcode constants and the two-step successor lookup.
package instr_sequencer_pkg;

    // Micro-state codes seen by Control_Unit.
    typedef enum logic [7:0] {
        RSTALL   = 8'h01, RSTAC    = 8'h02, RSTADDR  = 8'h03, RSTGSP   = 8'h04,
        RSTMC    = 8'h05, RSTCP    = 8'h06, RSTRP    = 8'h07, INCGSP   = 8'h08,
        INCAC    = 8'h09, INCCP    = 8'h0A, INCRP    = 8'h0B, INCMC    = 8'h0C,
        STSP     = 8'h0D, ADD      = 8'h0E, DIV      = 8'h0F, MOD      = 8'h10,
        MSTP     = 8'h11, MRP      = 8'h12, MCP      = 8'h13, MWV      = 8'h14,
        MEOPC    = 8'h15, MADDR    = 8'h16, MCID     = 8'h17, MMV      = 8'h18,
        MCIDAC   = 8'h19, MRPAC    = 8'h1A, MCPAC    = 8'h1B,
        LDADDR_1 = 8'h1C, LDADDR_2 = 8'h1D, LDAC_1   = 8'h1E, LDAC_2   = 8'h1F,
        LDMULR_1 = 8'h20, LDMULR_2 = 8'h21, LDRP_1   = 8'h22, LDRP_2   = 8'h23,
        LDCP_1   = 8'h24, LDCP_2   = 8'h25, MUL1     = 8'h26, MUL2     = 8'h27,
        JMP_1    = 8'h28, JMP_2    = 8'h29, JMPZ1Y_1 = 8'h2A, JMPZ1Y_2 = 8'h2B,
        JMPZ1N_1 = 8'h2C, JMPZ1N_2 = 8'h2D, JMPZ2Y_1 = 8'h2E, JMPZ2Y_2 = 8'h2F,
        JMPZ2N_1 = 8'h30, JMPZ2N_2 = 8'h31, FETCH_1  = 8'h32, FETCH_2  = 8'h33,
        DECODE   = 8'h34, ENDOP    = 8'h35
    } state_e;

    // Single-step opcodes share the numeric value of the state they execute in,
    // which lets the decoder pass them straight through.
    localparam logic [7:0] OP_RSTALL  = RSTALL,  OP_RSTAC  = RSTAC,  OP_RSTADDR = RSTADDR;
    localparam logic [7:0] OP_RSTGSP  = RSTGSP,  OP_RSTMC  = RSTMC,  OP_RSTCP   = RSTCP;
    localparam logic [7:0] OP_RSTRP   = RSTRP,   OP_INCGSP = INCGSP, OP_INCAC   = INCAC;
    localparam logic [7:0] OP_INCCP   = INCCP,   OP_INCRP  = INCRP,  OP_INCMC   = INCMC;
    localparam logic [7:0] OP_STSP    = STSP,    OP_ADD    = ADD,    OP_DIV     = DIV;
    localparam logic [7:0] OP_MOD     = MOD,     OP_MSTP   = MSTP,   OP_MRP     = MRP;
    localparam logic [7:0] OP_MCP     = MCP,     OP_MWV    = MWV,    OP_MEOPC   = MEOPC;
    localparam logic [7:0] OP_MADDR   = MADDR,   OP_MCID   = MCID,   OP_MMV     = MMV;
    localparam logic [7:0] OP_MCIDAC  = MCIDAC,  OP_MRPAC  = MRPAC,  OP_MCPAC   = MCPAC;
    // Two-step, branch and terminal opcodes.
    localparam logic [7:0] OP_LDADDR  = 8'h1C, OP_LDAC  = 8'h1D, OP_LDMULR = 8'h1E;
    localparam logic [7:0] OP_LDRP    = 8'h1F, OP_LDCP  = 8'h20, OP_MUL    = 8'h21;
    localparam logic [7:0] OP_JMP     = 8'h22, OP_JMPZ1 = 8'h23, OP_JMPZ2  = 8'h24;
    localparam logic [7:0] OP_ENDOP   = 8'h25;

    // Second micro-step of a two-step instruction.
    function automatic state_e step2_of(input state_e s);
        case (s)
            LDADDR_1: return LDADDR_2;
            LDAC_1:   return LDAC_2;
            LDMULR_1: return LDMULR_2;
            LDRP_1:   return LDRP_2;
            LDCP_1:   return LDCP_2;
            MUL1:     return MUL2;
            JMP_1:    return JMP_2;
            JMPZ1Y_1: return JMPZ1Y_2;
            JMPZ1N_1: return JMPZ1N_2;
            JMPZ2Y_1: return JMPZ2Y_2;
            JMPZ2N_1: return JMPZ2N_2;
            default:  return FETCH_1;
        endcase
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer and its environment: opcode/flag/ready inputs
// and the STATE/status outputs toward Control_Unit.
interface instr_sequencer_if #(
    parameter int CNT_W   = 16,
    parameter int STATE_W = 8
);
    logic [7:0]         INS;
    logic               Z1;
    logic               Z2;
    logic               mem_ready;
    logic               start;
    logic [STATE_W-1:0] STATE;
    logic               halted;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        output INS, Z1, Z2, mem_ready, start,
        input  STATE, halted, illegal, retired
    );

    modport slave (
        input  INS, Z1, Z2, mem_ready, start,
        output STATE, halted, illegal, retired
    );
endinterface

// File: rtl/instr_sequencer_op_decode.sv
// Combinational opcode decoder: first micro-state plus two-step, read-wait and
// illegal flags. Branch direction is resolved here from Z1/Z2.
module instr_sequencer_op_decode
    import instr_sequencer_pkg::*;
(
    input  logic [7:0] ins,
    input  logic       z1,
    input  logic       z2,
    output state_e     first_state,
    output logic       two_step,
    output logic       rd_wait,
    output logic       illegal_op
);

    // Opcode lookup; unknown codes fall to ENDOP with the illegal flag.
    always_comb begin
        first_state = ENDOP;
        two_step    = 1'b0;
        rd_wait     = 1'b0;
        illegal_op  = 1'b0;
        case (ins)
            OP_RSTALL, OP_RSTAC, OP_RSTADDR, OP_RSTGSP, OP_RSTMC, OP_RSTCP, OP_RSTRP,
            OP_INCGSP, OP_INCAC, OP_INCCP, OP_INCRP, OP_INCMC, OP_STSP, OP_ADD,
            OP_DIV, OP_MOD, OP_MSTP, OP_MRP, OP_MCP, OP_MWV, OP_MEOPC, OP_MADDR,
            OP_MCID, OP_MMV, OP_MCIDAC, OP_MRPAC, OP_MCPAC:
                first_state = state_e'(ins);
            OP_LDADDR: begin first_state = LDADDR_1; two_step = 1'b1; rd_wait = 1'b1; end
            OP_LDAC:   begin first_state = LDAC_1;   two_step = 1'b1; rd_wait = 1'b1; end
            OP_LDMULR: begin first_state = LDMULR_1; two_step = 1'b1; rd_wait = 1'b1; end
            OP_LDRP:   begin first_state = LDRP_1;   two_step = 1'b1; rd_wait = 1'b1; end
            OP_LDCP:   begin first_state = LDCP_1;   two_step = 1'b1; rd_wait = 1'b1; end
            OP_MUL:    begin first_state = MUL1;     two_step = 1'b1; end
            OP_JMP:    begin first_state = JMP_1;    two_step = 1'b1; end
            OP_JMPZ1:  begin first_state = z1 ? JMPZ1Y_1 : JMPZ1N_1; two_step = 1'b1; end
            OP_JMPZ2:  begin first_state = z2 ? JMPZ2Y_1 : JMPZ2N_1; two_step = 1'b1; end
            OP_ENDOP:  first_state = ENDOP;
            default:   illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Micro-step sequencer feeding Control_Unit STATE: fetch, decode, one- or
// two-step execution with memory-ready stalls, halt on ENDOP.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int STATE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.slave    bus
);

    state_e           state_q, state_d;
    logic             exec_q, exec_d;       // inside an instruction's micro-steps
    logic             two_q, two_d;         // a second step is still pending
    logic             wait_q, wait_d;       // current step waits for mem_ready
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    state_e dec_state;
    logic   dec_two, dec_wait, dec_illegal;

    instr_sequencer_op_decode u_op_decode (
        .ins         (bus.INS),
        .z1          (bus.Z1),
        .z2          (bus.Z2),
        .first_state (dec_state),
        .two_step    (dec_two),
        .rd_wait     (dec_wait),
        .illegal_op  (dec_illegal)
    );

    // Next micro-state, step bookkeeping and retirement.
    always_comb begin
        state_d   = state_q;
        exec_d    = exec_q;
        two_d     = two_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            FETCH_1: if (bus.mem_ready) state_d = FETCH_2;
            FETCH_2: state_d = DECODE;
            DECODE: begin
                state_d = dec_state;
                two_d   = dec_two;
                wait_d  = dec_wait;
                exec_d  = (dec_state != ENDOP);
                if (dec_illegal) illegal_d = 1'b1;
                else if (dec_state == ENDOP) retire = 1'b1;
            end
            ENDOP: if (bus.start) state_d = FETCH_1;
            default: begin
                // RSTALL straight out of reset is not an instruction step.
                if (!exec_q) begin
                    state_d = FETCH_1;
                end else if (!(wait_q && !bus.mem_ready)) begin
                    if (two_q) begin
                        state_d = step2_of(state_q);
                        two_d   = 1'b0;
                        wait_d  = 1'b0;
                    end else begin
                        state_d = FETCH_1;
                        exec_d  = 1'b0;
                        retire  = 1'b1;
                    end
                end
            end
        endcase
        retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    end

    // State and status registers; reset aborts any step in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RSTALL;
            exec_q    <= 1'b0;
            two_q     <= 1'b0;
            wait_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            exec_q    <= exec_d;
            two_q     <= two_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.STATE   = STATE_W'(state_q);
    assign bus.halted  = (state_q == ENDOP);
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand sequences for reset
// and counter wrap, and random instruction streams against a table model.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    typedef struct {
        logic [7:0] op;
        logic       z1;
        logic       z2;
        int         nf;    // cycles mem_ready held low in FETCH_1
        int         nr;    // cycles mem_ready held low in a read first-step
        logic       tog;   // invert Z flags after DECODE
        state_e     s1;
        state_e     s2;
        int         nst;   // 1 or 2 steps; 0 means the op halts
        logic       rd;
        logic       ill;
    } vec_t;

    typedef struct {
        logic   legal;
        logic   halt;
        state_e s1;
        state_e s2;
        int     nst;
        logic   rd;
        int     jz;    // 0 none, 1 JMPZ1, 2 JMPZ2
    } info_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    logic [15:0] exp_ret = '0;
    logic        exp_ill = 1'b0;
    info_t       info [256];
    logic [7:0]  legal_ops [$];

    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(16), .STATE_W(8)) b ();
    instr_sequencer_if #(.CNT_W(8),  .STATE_W(8)) b2 ();

    instr_sequencer #(.CNT_W(16), .STATE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    instr_sequencer #(.CNT_W(8), .STATE_W(8)) dut_w (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (b2)
    );

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t mk(logic [7:0] op, logic z1, logic z2, int nf, int nr,
                                logic tog, state_e s1, state_e s2, int nst, logic rd,
                                logic ill);
        vec_t v;
        v.op = op; v.z1 = z1; v.z2 = z2; v.nf = nf; v.nr = nr; v.tog = tog;
        v.s1 = s1; v.s2 = s2; v.nst = nst; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    // Reference model: instruction table keyed by opcode.
    task automatic build_model();
        logic [7:0] sop [27] = '{OP_RSTALL, OP_RSTAC, OP_RSTADDR, OP_RSTGSP, OP_RSTMC,
            OP_RSTCP, OP_RSTRP, OP_INCGSP, OP_INCAC, OP_INCCP, OP_INCRP, OP_INCMC,
            OP_STSP, OP_ADD, OP_DIV, OP_MOD, OP_MSTP, OP_MRP, OP_MCP, OP_MWV, OP_MEOPC,
            OP_MADDR, OP_MCID, OP_MMV, OP_MCIDAC, OP_MRPAC, OP_MCPAC};
        state_e sst [27] = '{RSTALL, RSTAC, RSTADDR, RSTGSP, RSTMC, RSTCP, RSTRP,
            INCGSP, INCAC, INCCP, INCRP, INCMC, STSP, ADD, DIV, MOD, MSTP, MRP, MCP,
            MWV, MEOPC, MADDR, MCID, MMV, MCIDAC, MRPAC, MCPAC};
        logic [7:0] top [7] = '{OP_LDADDR, OP_LDAC, OP_LDMULR, OP_LDRP, OP_LDCP, OP_MUL, OP_JMP};
        state_e t1 [7] = '{LDADDR_1, LDAC_1, LDMULR_1, LDRP_1, LDCP_1, MUL1, JMP_1};
        state_e t2 [7] = '{LDADDR_2, LDAC_2, LDMULR_2, LDRP_2, LDCP_2, MUL2, JMP_2};
        logic   trd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 256; i++) begin
            info[i] = '{legal: 1'b0, halt: 1'b1, s1: ENDOP, s2: ENDOP, nst: 0, rd: 1'b0, jz: 0};
        end
        for (int i = 0; i < 27; i++) begin
            info[sop[i]] = '{legal: 1'b1, halt: 1'b0, s1: sst[i], s2: sst[i], nst: 1, rd: 1'b0, jz: 0};
            legal_ops.push_back(sop[i]);
        end
        for (int i = 0; i < 7; i++) begin
            info[top[i]] = '{legal: 1'b1, halt: 1'b0, s1: t1[i], s2: t2[i], nst: 2, rd: trd[i], jz: 0};
            legal_ops.push_back(top[i]);
        end
        info[OP_JMPZ1] = '{legal: 1'b1, halt: 1'b0, s1: JMPZ1N_1, s2: JMPZ1N_2, nst: 2, rd: 1'b0, jz: 1};
        info[OP_JMPZ2] = '{legal: 1'b1, halt: 1'b0, s1: JMPZ2N_1, s2: JMPZ2N_2, nst: 2, rd: 1'b0, jz: 2};
        legal_ops.push_back(OP_JMPZ1);
        legal_ops.push_back(OP_JMPZ2);
        info[OP_ENDOP] = '{legal: 1'b1, halt: 1'b1, s1: ENDOP, s2: ENDOP, nst: 0, rd: 1'b0, jz: 0};
    endtask

    function automatic vec_t model_vec(logic [7:0] op, logic z1, logic z2, int nf, int nr, logic tog);
        info_t  m = info[op];
        state_e s1 = m.s1;
        state_e s2 = m.s2;
        if (m.jz == 1 && z1) begin s1 = JMPZ1Y_1; s2 = JMPZ1Y_2; end
        if (m.jz == 2 && z2) begin s1 = JMPZ2Y_1; s2 = JMPZ2Y_2; end
        return mk(op, z1, z2, nf, nr, tog, s1, s2, m.halt ? 0 : m.nst, m.rd, !m.legal);
    endfunction

    task automatic chk(input state_e es, input string nm);
        logic eh;
        eh = (es == ENDOP);
        nchk++;
        if (b.STATE !== es || b.halted !== eh || b.illegal !== exp_ill || b.retired !== exp_ret) begin
            nerr++;
            $display("FAIL %s: got STATE=%h halted=%b illegal=%b retired=%0d, want STATE=%h halted=%b illegal=%b retired=%0d",
                     nm, b.STATE, b.halted, b.illegal, b.retired, es, eh, exp_ill, exp_ret);
        end
    endtask

    task automatic misc_rand();
        b.start = rbit();
        b.Z1 = rbit();
        b.Z2 = rbit();
    endtask

    task automatic after_decode(input vec_t v);
        b.start = rbit();
        b.Z1 = v.tog ? ~v.z1 : rbit();
        b.Z2 = v.tog ? ~v.z2 : rbit();
    endtask

    // Apply one instruction starting at its first FETCH_1 cycle.
    task automatic run_vec(input vec_t v, input string nm);
        b.INS = v.op;
        for (int i = 0; i < v.nf; i++) begin
            @(negedge clk); chk(FETCH_1, nm); b.mem_ready = 1'b0; misc_rand();
        end
        @(negedge clk); chk(FETCH_1, nm); b.mem_ready = 1'b1; misc_rand();
        @(negedge clk); chk(FETCH_2, nm); b.mem_ready = rbit(); misc_rand();
        @(negedge clk); chk(DECODE, nm);  b.mem_ready = rbit(); b.start = rbit();
        b.Z1 = v.z1; b.Z2 = v.z2;
        if (v.nst == 0) begin
            if (v.ill) exp_ill = 1'b1;
            else exp_ret++;
            @(negedge clk); chk(ENDOP, nm); b.start = 1'b0; b.mem_ready = rbit();
        end else begin
            for (int i = 0; i < (v.rd ? v.nr : 0); i++) begin
                @(negedge clk); chk(v.s1, nm); b.mem_ready = 1'b0; after_decode(v);
            end
            @(negedge clk); chk(v.s1, nm); b.mem_ready = v.rd ? 1'b1 : rbit(); after_decode(v);
            if (v.nst == 2) begin
                @(negedge clk); chk(v.s2, nm); b.mem_ready = rbit(); after_decode(v);
            end
            exp_ret++;
        end
    endtask

    // Sit in ENDOP for a while, then pulse start.
    task automatic resume(input int idle, input string nm);
        for (int i = 0; i < idle; i++) begin
            @(negedge clk); chk(ENDOP, nm); b.start = 1'b0; b.mem_ready = rbit();
            b.INS = 8'($urandom_range(0, 255));
        end
        @(negedge clk); chk(ENDOP, nm); b.start = 1'b1;
        @(posedge clk); #1 b.start = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [$];
        vec_t v;
        logic [7:0] op;
        int r;
        logic found;
        state_e wst [4] = '{FETCH_2, DECODE, ADD, FETCH_1};
        logic [7:0] wret [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};

        b.INS = OP_ADD; b.Z1 = 1'b0; b.Z2 = 1'b0; b.mem_ready = 1'b1; b.start = 1'b0;
        b2.INS = OP_ADD; b2.Z1 = 1'b0; b2.Z2 = 1'b0; b2.mem_ready = 1'b1; b2.start = 1'b0;
        build_model();

        tbl.push_back(mk(OP_ADD,    1'b0, 1'b0, 0, 0, 1'b0, ADD,      ADD,      1, 1'b0, 1'b0));
        tbl.push_back(mk(OP_LDAC,   1'b0, 1'b0, 0, 3, 1'b0, LDAC_1,   LDAC_2,   2, 1'b1, 1'b0));
        tbl.push_back(mk(OP_JMPZ1,  1'b1, 1'b0, 0, 0, 1'b1, JMPZ1Y_1, JMPZ1Y_2, 2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_JMPZ1,  1'b0, 1'b1, 0, 0, 1'b1, JMPZ1N_1, JMPZ1N_2, 2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_JMPZ2,  1'b0, 1'b1, 1, 0, 1'b1, JMPZ2Y_1, JMPZ2Y_2, 2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_JMPZ2,  1'b1, 1'b0, 0, 0, 1'b1, JMPZ2N_1, JMPZ2N_2, 2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_MUL,    1'b0, 1'b0, 2, 0, 1'b0, MUL1,     MUL2,     2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_LDADDR, 1'b0, 1'b0, 1, 2, 1'b0, LDADDR_1, LDADDR_2, 2, 1'b1, 1'b0));
        tbl.push_back(mk(OP_JMP,    1'b0, 1'b0, 0, 0, 1'b0, JMP_1,    JMP_2,    2, 1'b0, 1'b0));
        tbl.push_back(mk(OP_LDMULR, 1'b0, 1'b0, 0, 1, 1'b0, LDMULR_1, LDMULR_2, 2, 1'b1, 1'b0));
        tbl.push_back(mk(OP_LDRP,   1'b0, 1'b0, 0, 0, 1'b0, LDRP_1,   LDRP_2,   2, 1'b1, 1'b0));
        tbl.push_back(mk(OP_LDCP,   1'b0, 1'b0, 0, 2, 1'b0, LDCP_1,   LDCP_2,   2, 1'b1, 1'b0));
        tbl.push_back(mk(OP_RSTALL, 1'b0, 1'b0, 0, 0, 1'b0, RSTALL,   RSTALL,   1, 1'b0, 1'b0));
        tbl.push_back(mk(OP_MCPAC,  1'b0, 1'b0, 1, 0, 1'b0, MCPAC,    MCPAC,    1, 1'b0, 1'b0));
        tbl.push_back(mk(OP_INCGSP, 1'b0, 1'b0, 0, 0, 1'b0, INCGSP,   INCGSP,   1, 1'b0, 1'b0));
        tbl.push_back(mk(OP_ENDOP,  1'b0, 1'b0, 0, 0, 1'b0, ENDOP,    ENDOP,    0, 1'b0, 1'b0));
        tbl.push_back(mk(8'hFF,     1'b0, 1'b0, 0, 0, 1'b0, ENDOP,    ENDOP,    0, 1'b0, 1'b1));
        tbl.push_back(mk(OP_DIV,    1'b0, 1'b0, 0, 0, 1'b0, DIV,      DIV,      1, 1'b0, 1'b0));

        // Reset state and release.
        @(negedge clk); chk(RSTALL, "reset");
        @(negedge clk); chk(RSTALL, "reset_hold");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk(RSTALL, "first_after_release");

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
            if (tbl[i].nst == 0) resume(2, $sformatf("vec%0d_halt", i));
        end

        // Asynchronous reset in the middle of MUL1.
        b.INS = OP_MUL;
        @(negedge clk); chk(FETCH_1, "mulrst_f1"); b.mem_ready = 1'b1;
        @(negedge clk); chk(FETCH_2, "mulrst_f2");
        @(negedge clk); chk(DECODE, "mulrst_dec");
        @(negedge clk); chk(MUL1, "mulrst_mul1");
        #3 rst_n = 1'b0;
        #1 exp_ret = '0; exp_ill = 1'b0;
        chk(RSTALL, "async_reset_mul1");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk(RSTALL, "mulrst_release");
        run_vec(model_vec(OP_ADD, 1'b0, 1'b0, 0, 0, 1'b0), "mulrst_restart");

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 88) begin
                op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
            end else if (r < 94) begin
                op = OP_ENDOP;
            end else begin
                op = 8'hFF;
                for (int k = 0; k < 20; k++) begin
                    op = 8'($urandom_range(0, 255));
                    if (!info[op].legal) break;
                end
                if (info[op].legal) op = 8'hFF;
            end
            v = model_vec(op, rbit(), rbit(), $urandom_range(0, 2), $urandom_range(0, 3), rbit());
            run_vec(v, $sformatf("rand%0d", n));
            if (v.nst == 0) resume($urandom_range(0, 3), $sformatf("rand%0d_halt", n));
        end

        // Counter wrap on an 8-bit instance running back-to-back ADDs.
        @(posedge clk); #1 rst2_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (b2.retired == 8'hFF) found = 1'b1;
        end
        nchk++;
        if (!found || b2.STATE !== FETCH_1) begin
            nerr++;
            $display("FAIL wrap_reach: got reached=%b STATE=%h, want reached=1 STATE=%h", found, b2.STATE, FETCH_1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nchk++;
            if (b2.STATE !== wst[i] || b2.retired !== wret[i]) begin
                nerr++;
                $display("FAIL wrap_step%0d: got STATE=%h retired=%h, want STATE=%h retired=%h",
                         i, b2.STATE, b2.retired, wst[i], wret[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Micro-step sequencer that sits directly upstream of Control_Unit and drives its 8-bit STATE input every cycle.
- Steps through fetch, decode and the one- or two-step micro-sequence of each instruction.
- Resolves JMPZ1/JMPZ2 branches from the Z1/Z2 flags and stalls memory-read steps until memory signals ready.
- Halts on ENDOP and flags illegal opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- STATE_W, 8, width of the micro-state code (matches Control_Unit STATE).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- INS  input  8  opcode from the instruction register; valid from the cycle after FETCH_2.
- Z1  input  1  zero flag 1, sampled in DECODE.
- Z2  input  1  zero flag 2, sampled in DECODE.
- mem_ready  input  1  memory read data valid this cycle.
- start  input  1  single-cycle pulse; leaves the halted state.
- STATE  output  STATE_W  current micro-state code to Control_Unit.
- halted  output  1  high while STATE==ENDOP.
- illegal  output  1  sticky; set on an undecodable opcode.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): STATE=RSTALL, halted=0, illegal=0, retired=0.
- Reset assertion mid-sequence aborts the sequence immediately. No partial step completes.
- First cycle after reset release: STATE=RSTALL, then FETCH_1.
- FETCH_1: hold while mem_ready=0. When mem_ready=1, go to FETCH_2.
- FETCH_2: always go to DECODE.
  - DECODE is a new state code in define.v. Control_Unit drives idle outputs for it through its default branch.
- DECODE: case on INS against the OP_* constants.
  - Single-step ops go to their state, then FETCH_1: RSTALL/RSTAC/RSTADDR/RSTGSP/RSTMC/RSTCP/RSTRP, INCGSP/INCAC/INCCP/INCRP/INCMC, STSP, ADD, DIV, MOD, MSTP/MRP/MCP/MWV/MEOPC/MADDR/MCID/MMV, MCIDAC/MRPAC/MCPAC.
  - Two-step ops go X_1 -> X_2 -> FETCH_1: LDADDR, LDAC, LDMULR, LDRP, LDCP, MUL (MUL1 -> MUL2), JMP.
  - JMPZ1: Z1=1 gives JMPZ1Y_1 -> JMPZ1Y_2; Z1=0 gives JMPZ1N_1 -> JMPZ1N_2. JMPZ2 works the same on Z2.
  - Z1/Z2 are sampled only in DECODE. Later flag changes do not alter the chosen path.
  - OP_ENDOP goes to ENDOP.
  - Any other INS value goes to ENDOP and sets illegal.
- Memory-read first steps (LDADDR_1, LDAC_1, LDMULR_1, LDRP_1, LDCP_1) hold while mem_ready=0. They advance to _2 on the cycle mem_ready=1.
- Non-read steps never wait; mem_ready is ignored there.
- retired increments by 1 on every transition into FETCH_1 from a final micro-step, and on entry to ENDOP via OP_ENDOP.
  - It does not increment after RSTALL at reset or on an illegal opcode.
  - It wraps from all-ones to 0.
- ENDOP: halted=1. Stay in ENDOP until start=1, then go to FETCH_1.
  - start is ignored in every other state.
  - illegal clears only on reset.
- Latency with mem_ready tied high:
  - Single-step instruction: 4 cycles (FETCH_1, FETCH_2, DECODE, op).
  - Two-step instruction: 5 cycles.
- STATE is a registered output with no combinational path from inputs.
  - Control_Unit registers again, so control outputs lag STATE by one cycle.

Decomposition:
- define.v (shared) gains:
  - OP_* opcode constants, one per instruction.
  - `DECODE state code.
  - A MEMRD_STEP list of read first-steps.
- Existing state-code macros are reused unchanged.
- One natural sub-module: op_decode. It is combinational, maps INS plus Z1/Z2 to the first state, a two-step flag, a read-wait flag and an illegal flag.

Test Plan:
- Reset release with mem_ready=1, INS=OP_ADD: STATE sequence is RSTALL, FETCH_1, FETCH_2, DECODE, ADD, FETCH_1; retired=1.
- INS=OP_LDAC with mem_ready low for 3 cycles in LDAC_1: LDAC_1 is held 4 cycles, then LDAC_2, then FETCH_1.
- INS=OP_JMPZ1, Z1=1 at DECODE then toggled to 0: path is JMPZ1Y_1, JMPZ1Y_2. Repeat with Z1=0: path is JMPZ1N_1, JMPZ1N_2.
- INS=8'hFF (undefined): DECODE goes to ENDOP; illegal=1, halted=1, retired unchanged. start pulse leads to FETCH_1 with illegal still 1.
- rst_n pulled low during MUL1: STATE=RSTALL immediately, retired=0, illegal=0. Sequence restarts at FETCH_1.
- Preload retired to 16'hFFFF by running 65535 ADDs, then one more ADD: retired=0.
